axi4_lite_write_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one AXI4-lite write path (the WRITE_ADDR / WRITE_DATA / WRITE_START / WRITE_DONE front-end of the write master/slave pair) between N_REQ requesters, e.g. LSU stores and CSR/debug writes. It latches one request, issues a single write, waits for completion and returns done/error to the winner. A timeout watchdog releases a requester if the write path never answers.

---
 rtl/axi4_lite_write_arbiter_pkg.sv | 34 +++
 rtl/axi4_lite_write_arbiter_if.sv | 50 +++++
 rtl/axi4_lite_write_arbiter_rr_pick.sv | 40 ++++
 rtl/axi4_lite_write_arbiter.sv | 144 ++++++++++++++
 tb/tb_axi4_lite_write_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_write_arbiter_pkg.sv
// axi4_lite_write_arbiter_pkg
// Shared definitions for the write-path arbiter slice:
//   - default widths and requester count
//   - arbiter FSM state encoding (also exported on the debug port)
//   - AXI response codes shared with the write master/slave pair
//   - gnt_w(): width of a requester index
package axi4_lite_write_arbiter_pkg;

   localparam int DEF_N_REQ   = 2;
   localparam int DEF_ADDR_W  = 64;
   localparam int DEF_DATA_W  = 64;
   localparam int DEF_TIMEOUT = 256;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_DRAIN = 3'd4
   } arb_state_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   // Requester index width; N_REQ is always >= 2 so this is never 0.
   function automatic int gnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axi4_lite_write_arbiter_if.sv
// axi4_lite_write_arbiter_if
// Bundles the requester side and the write-path side of the arbiter.
//   req_valid/req_addr/req_data : requester inputs (packed, requester i at [i*W +: W])
//   req_ready/req_done/req_err  : per-requester accept / completion / timeout flag
//   write_addr/write_data/write_start/write_done : shared write path
//   busy/cur_grant              : status
//
// Handshake: a requester holds req_valid high (level) until it sees its
// req_ready pulse; the address/data on that cycle are latched and the
// requester may then drop or change them. req_ready is only ever given while
// the arbiter is idle, and completion is reported by a one-cycle req_done
// pulse, with req_err qualifying it in that same cycle.
//
// modport master : the arbiter
// modport slave  : requesters plus write path
interface axi4_lite_write_arbiter_if
   import axi4_lite_write_arbiter_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   localparam int GW = gnt_w(N_REQ);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ-1:0]        req_done;
   logic                    req_err;
   logic [ADDR_W-1:0]       write_addr;
   logic [DATA_W-1:0]       write_data;
   logic                    write_start;
   logic                    write_done;
   logic                    busy;
   logic [GW-1:0]           cur_grant;

   modport master (
      input  req_valid, req_addr, req_data, write_done,
      output req_ready, req_done, req_err, write_addr, write_data,
             write_start, busy, cur_grant
   );

   modport slave (
      output req_valid, req_addr, req_data, write_done,
      input  req_ready, req_done, req_err, write_addr, write_data,
             write_start, busy, cur_grant
   );

endinterface

// File: rtl/axi4_lite_write_arbiter_rr_pick.sv
// axi4_lite_write_arbiter_rr_pick
// Combinational round-robin picker.
//   req       : request vector
//   last      : index of the previous winner
//   grant_oh  : one-hot winner (first set bit above last, wrapping)
//   grant_idx : index of the winner
//   any       : at least one request present
module axi4_lite_write_arbiter_rr_pick
   import axi4_lite_write_arbiter_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   localparam int GW   = gnt_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [GW-1:0]    last,
   output logic [N_REQ-1:0] grant_oh,
   output logic [GW-1:0]    grant_idx,
   output logic             any
);

   logic [GW-1:0] idx;

   // Walk offsets from farthest to nearest so the nearest requester above
   // 'last' overwrites any earlier hit and ends up as the winner.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      idx       = '0;
      any       = |req;
      for (int off = N_REQ; off >= 1; off--) begin
         idx = GW'((int'(last) + off) % N_REQ);
         if (req[idx]) begin
            grant_oh      = '0;
            grant_oh[idx] = 1'b1;
            grant_idx     = idx;
         end
      end
   end

endmodule

// File: rtl/axi4_lite_write_arbiter.sv
// axi4_lite_write_arbiter
// Shares one write path among N_REQ requesters: round-robin grant, single
// write issue, completion return, and a watchdog that answers the requester
// with an error if the write path stays silent for TIMEOUT cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester and write-path signals (master modport)
//   dbg_state  : current FSM state
module axi4_lite_write_arbiter
   import axi4_lite_write_arbiter_pkg::*;
#(
   parameter int N_REQ   = DEF_N_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   axi4_lite_write_arbiter_if.master     bus,
   output arb_state_e                    dbg_state
);

   localparam int GW = gnt_w(N_REQ);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
   localparam logic [GW-1:0] LAST_INIT = GW'(N_REQ - 1);

   arb_state_e        state;
   logic [GW-1:0]     last_grant;
   logic [CW-1:0]     cnt;
   logic              drain;
   logic [N_REQ-1:0]  win_oh;

   logic [N_REQ-1:0]  req_done_q;
   logic              req_err_q;
   logic              write_start_q;
   logic [ADDR_W-1:0] write_addr_q;
   logic [DATA_W-1:0] write_data_q;
   logic [GW-1:0]     cur_grant_q;

   logic [N_REQ-1:0]  pick_oh;
   logic [GW-1:0]     pick_idx;
   logic              pick_any;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   axi4_lite_write_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req       (bus.req_valid),
      .last      (last_grant),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx),
      .any       (pick_any)
   );

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_oh[i]) begin
            sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            sel_data = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         last_grant    <= LAST_INIT;
         cnt           <= '0;
         drain         <= 1'b0;
         win_oh        <= '0;
         req_done_q    <= '0;
         req_err_q     <= 1'b0;
         write_start_q <= 1'b0;
         write_addr_q  <= '0;
         write_data_q  <= '0;
         cur_grant_q   <= '0;
      end else begin
         req_done_q    <= '0;
         req_err_q     <= 1'b0;
         write_start_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  last_grant    <= pick_idx;
                  cur_grant_q   <= pick_idx;
                  win_oh        <= pick_oh;
                  write_addr_q  <= sel_addr;
                  write_data_q  <= sel_data;
                  write_start_q <= 1'b1;   // high for exactly the ISSUE cycle
                  cnt           <= '0;
                  state         <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (bus.write_done) begin
                  req_done_q <= win_oh;
                  state      <= ST_RESP;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // A completion on the last watchdog cycle still counts as success.
               if (bus.write_done) begin
                  req_done_q <= win_oh;
                  state      <= ST_RESP;
               end else if (cnt == CNT_LAST) begin
                  req_done_q <= win_oh;
                  req_err_q  <= 1'b1;
                  drain      <= 1'b1;
                  state      <= ST_RESP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_RESP: begin
               state <= drain ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
               // Swallow the late completion of the abandoned write.
               if (bus.write_done) begin
                  drain <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Acceptance is answered in the same cycle the request is seen; it is
   // gated by reset so nothing is accepted while the block is held in reset.
   assign bus.req_ready   = (rst_n && state == ST_IDLE) ? pick_oh : '0;
   assign bus.req_done    = req_done_q;
   assign bus.req_err     = req_err_q;
   assign bus.write_start = write_start_q;
   assign bus.write_addr  = write_addr_q;
   assign bus.write_data  = write_data_q;
   assign bus.cur_grant   = cur_grant_q;
   assign bus.busy        = (state != ST_IDLE);
   assign dbg_state       = state;

endmodule

// File: tb/tb_axi4_lite_write_arbiter.sv
// tb_axi4_lite_write_arbiter
// Bench for the shared write-path arbiter: directed vector table, reset
// sequences and randomized transactions against a transaction-level model.
module tb_axi4_lite_write_arbiter;
   import axi4_lite_write_arbiter_pkg::*;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       rst_n;
   arb_state_e dbg_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   axi4_lite_write_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   axi4_lite_write_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard / model ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [N:0]    exp_q[$];      // {err, one-hot requester}
   int            model_last;
   logic [AW-1:0] a_tab[N];
   logic [DW-1:0] d_tab[N];

   typedef struct {
      logic [N-1:0] mask;
      int           k;        // cycle offset of write_done from the start cycle
      int           k2;       // optional second write_done pulse, -1 = none
      int           exp_g;
      bit           exp_err;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Winner = first requesting index visited when walking the ring upward
   // from the previous winner.
   function automatic int model_pick(input logic [N-1:0] mask, input int last);
      int order[$];
      logic [N-1:0] m;
      for (int j = 1; j <= N; j++) order.push_back((last + j) % N);
      foreach (order[i]) begin
         m = mask >> order[i];
         if (m[0]) return order[i];
      end
      return -1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic rand_tabs();
      for (int i = 0; i < N; i++) begin
         a_tab[i] = AW'($urandom());
         d_tab[i] = DW'($urandom());
      end
   endtask

   task automatic pack_tabs();
      for (int i = 0; i < N; i++) begin
         bus.req_addr[i*AW +: AW] = a_tab[i];
         bus.req_data[i*DW +: DW] = d_tab[i];
      end
   endtask

   task automatic scramble_inputs();
      for (int i = 0; i < N; i++) begin
         bus.req_addr[i*AW +: AW] = AW'($urandom());
         bus.req_data[i*DW +: DW] = DW'($urandom());
      end
   endtask

   // Called just after a negedge with the DUT idle. Returns just after the
   // negedge of the first idle cycle following the transaction.
   task automatic run_txn(input logic [N-1:0] mask, input int k, input int k2,
                          input int exp_g, input bit exp_err, input bit drop_valid);
      logic [N-1:0]  oh;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      int resp_c, end_c;
      bit done_ok;
      oh = N'(1) << exp_g;
      pack_tabs();
      bus.req_valid  = mask;
      bus.write_done = 1'b0;
      #1;
      check("idle_busy", bus.busy, 0);
      check("grant_ready", bus.req_ready, oh);
      ea = a_tab[exp_g];
      ed = d_tab[exp_g];
      exp_q.push_back({exp_err, oh});
      model_last = exp_g;
      resp_c = exp_err ? TO + 1 : k + 1;
      end_c  = -1;
      if (exp_err) begin
         if (k >= TO + 2) end_c = k;
         if (k2 >= TO + 2 && (end_c < 0 || k2 < end_c)) end_c = k2;
      end
      done_ok = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 300; c++) begin
         bus.write_done = (c == k) || (c == k2);
         if (drop_valid) bus.req_valid = '0;
         scramble_inputs();
         #1;
         check("write_start", bus.write_start, (c == 0) ? 1 : 0);
         check("write_addr", bus.write_addr, ea);
         check("write_data", bus.write_data, ed);
         check("cur_grant", bus.cur_grant, exp_g);
         check("busy_active", bus.busy, 1);
         check("no_ready_busy", bus.req_ready, 0);
         if (c == resp_c) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", 1, 0);
            end else begin
               logic [N:0] e;
               e = exp_q.pop_front();
               check("done_onehot", bus.req_done, e[N-1:0]);
               check("done_err", bus.req_err, e[N]);
            end
         end else begin
            check("no_done", bus.req_done, 0);
         end
         if ((!exp_err && c == resp_c) || (exp_err && c == end_c)) begin
            done_ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!done_ok) check("txn_bound", 0, 1);
      @(negedge clk);
      bus.write_done = 1'b0;
      bus.req_valid  = '0;
      #1;
      check("back_idle", bus.busy, 0);
      check("idle_no_done", bus.req_done, 0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ready"}, bus.req_ready, 0);
      check({tag, "_done"}, bus.req_done, 0);
      check({tag, "_err"}, bus.req_err, 0);
      check({tag, "_start"}, bus.write_start, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_addr"}, bus.write_addr, 0);
      check({tag, "_data"}, bus.write_data, 0);
      check({tag, "_grant"}, bus.cur_grant, 0);
      check({tag, "_state"}, dbg_state, ST_IDLE);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [N-1:0] mask;
      int k, g;

      vecs[0]  = '{3'b001, 3,  -1, 0, 1'b0};  // single write
      vecs[1]  = '{3'b011, 1,  -1, 1, 1'b0};  // contention 0,1,0,1
      vecs[2]  = '{3'b011, 0,  -1, 0, 1'b0};  // fast path
      vecs[3]  = '{3'b011, 2,  -1, 1, 1'b0};
      vecs[4]  = '{3'b011, 0,  -1, 0, 1'b0};
      vecs[5]  = '{3'b111, 1,  -1, 1, 1'b0};
      vecs[6]  = '{3'b111, 0,  -1, 2, 1'b0};
      vecs[7]  = '{3'b111, 8,  -1, 0, 1'b0};  // done on the exact timeout cycle
      vecs[8]  = '{3'b100, 4,  -1, 2, 1'b0};
      vecs[9]  = '{3'b101, 10, -1, 0, 1'b1};  // timeout, late done in drain
      vecs[10] = '{3'b110, 9,  12, 1, 1'b1};  // done during RESP ignored
      vecs[11] = '{3'b010, 2,  -1, 1, 1'b0};
      vecs[12] = '{3'b001, 5,  -1, 0, 1'b0};

      rst_n          = 1'b0;
      bus.req_valid  = '1;
      bus.req_addr   = '1;
      bus.req_data   = '1;
      bus.write_done = 1'b0;
      model_last     = N - 1;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      bus.req_valid = '0;
      rst_n = 1'b1;
      #1;

      // Directed vector table
      for (int i = 0; i < 13; i++) begin
         rand_tabs();
         if (i == 0) begin
            a_tab[0] = 32'h8000_0010;
            d_tab[0] = 32'hDEAD_BEEF;
         end
         run_txn(vecs[i].mask, vecs[i].k, vecs[i].k2, vecs[i].exp_g, vecs[i].exp_err, 1'b0);
      end

      // Reset in the middle of WAIT
      rand_tabs();
      pack_tabs();
      bus.req_valid = 3'b110;
      @(negedge clk);   // ISSUE
      @(negedge clk);   // WAIT
      @(negedge clk);   // WAIT
      #2 rst_n = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      @(negedge clk);
      bus.req_valid = '0;
      rst_n = 1'b1;
      exp_q.delete();
      model_last = N - 1;
      #1;
      rand_tabs();
      run_txn(3'b011, 2, -1, 0, 1'b0, 1'b0);   // requester 0 wins first again

      // Randomized transactions against the model
      for (int i = 0; i < 40; i++) begin
         mask = N'($urandom_range(1, (1 << N) - 1));
         if ($urandom_range(0, 9) < 7) k = $urandom_range(0, TO);
         else k = $urandom_range(TO + 2, TO + 6);
         g = model_pick(mask, model_last);
         rand_tabs();
         run_txn(mask, k, -1, g, (k > TO), 1'($urandom_range(0, 1)));
      end

      check("sb_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
